bus_transfer_ctrl: RTL and testbench

// Destination-side controller for the shared 32-bit main bus. The main bus mux selects one source

---
 rtl/bus_transfer_ctrl.sv | 151 +++++++++++++++
 tb/tb_bus_transfer_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_ctrl.sv
// Destination-side controller for the shared main bus: drives one one-hot source enable,
// captures the bus value and delivers it to an ALU operand latch, the register bank or memory.
module bus_transfer_ctrl #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_src,
  input  logic [1:0]        req_dst,
  input  logic [4:0]        req_rd_addr,
  output logic              src_alu,
  output logic              src_register_bank,
  output logic              src_decoder,
  output logic              src_memory,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] alu_a_q,
  output logic [DATA_W-1:0] alu_b_q,
  output logic              rb_we,
  output logic [4:0]        rb_waddr,
  output logic              mem_we,
  output logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_RB  = 2'd1;
  localparam logic [1:0] SRC_DEC = 2'd2;
  localparam logic [1:0] SRC_MEM = 2'd3;
  localparam logic [1:0] DST_A   = 2'd0;
  localparam logic [1:0] DST_B   = 2'd1;
  localparam logic [1:0] DST_RB  = 2'd2;
  localparam logic [1:0] DST_MEM = 2'd3;

  typedef enum logic [1:0] {IDLE, DRIVE, WRITE, FIN} state_t;

  state_t           state, state_nxt;
  logic [1:0]       src_q, dst_q;
  logic             err_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;

  assign wait_expired = (wait_cnt == CNT_LAST) && !mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Enables and strobes are decoded from the state register only, so reset drops them at once.
  always_comb begin
    state_nxt         = state;
    req_ready         = 1'b0;
    src_alu           = 1'b0;
    src_register_bank = 1'b0;
    src_decoder       = 1'b0;
    src_memory        = 1'b0;
    rb_we             = 1'b0;
    mem_we            = 1'b0;
    done              = 1'b0;
    err               = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nxt = (req_src == SRC_MEM && req_dst == DST_MEM) ? FIN : DRIVE;
      end
      DRIVE: begin
        case (src_q)
          SRC_ALU: src_alu           = 1'b1;
          SRC_RB:  src_register_bank = 1'b1;
          SRC_DEC: src_decoder       = 1'b1;
          default: src_memory        = 1'b1;
        endcase
        if (src_q != SRC_MEM || mem_ack) state_nxt = WRITE;
        else if (wait_expired)           state_nxt = FIN;
      end
      WRITE: begin
        rb_we  = (dst_q == DST_RB);
        mem_we = (dst_q == DST_MEM);
        if (dst_q != DST_MEM || mem_ack || wait_expired) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture, bus sampling, operand latches and the shared memory wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q    <= '0;
      dst_q    <= '0;
      rb_waddr <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
      wdata    <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            src_q    <= req_src;
            dst_q    <= req_dst;
            rb_waddr <= req_rd_addr;
            err_q    <= (req_src == SRC_MEM && req_dst == DST_MEM);
            wait_cnt <= '0;
          end
        end
        DRIVE: begin
          if (src_q != SRC_MEM) begin
            wdata <= bus_in;
          end else if (mem_ack) begin
            wdata    <= bus_in;
            wait_cnt <= '0;
          end else if (wait_expired) begin
            err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        WRITE: begin
          case (dst_q)
            DST_A: alu_a_q <= wdata;
            DST_B: alu_b_q <= wdata;
            DST_MEM: begin
              if (!mem_ack) begin
                if (wait_expired) err_q <= 1'b1;
                else              wait_cnt <= wait_cnt + CNT_W'(1);
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_transfer_ctrl.sv
// Self-checking bench for bus_transfer_ctrl: a transaction-level model builds the expected
// per-cycle trace, a single compare process checks it, and literal checks pin key values.
module tb_bus_transfer_ctrl;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_src, req_dst;
  logic [4:0]  req_rd_addr;
  logic        src_alu, src_register_bank, src_decoder, src_memory;
  logic [31:0] bus_in;
  logic        mem_ack;
  logic [31:0] alu_a_q, alu_b_q, wdata;
  logic        rb_we, mem_we, done, err;
  logic [4:0]  rb_waddr;

  bus_transfer_ctrl #(.DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src(req_src), .req_dst(req_dst), .req_rd_addr(req_rd_addr),
    .src_alu(src_alu), .src_register_bank(src_register_bank),
    .src_decoder(src_decoder), .src_memory(src_memory),
    .bus_in(bus_in), .mem_ack(mem_ack), .alu_a_q(alu_a_q), .alu_b_q(alu_b_q),
    .rb_we(rb_we), .rb_waddr(rb_waddr), .mem_we(mem_we), .wdata(wdata),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] a, b, w;
    logic [4:0]  wa;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        cur;
  int          checks = 0;
  int          passes = 0;
  int          mem_we_cycles, src_mem_cycles;
  logic [31:0] m_a, m_b, m_w;
  logic [4:0]  m_wa;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  function automatic logic [8:0] mk(input logic rdy, input logic [3:0] oh, input logic rbw,
                                    input logic mw, input logic dn, input logic er);
    return {rdy, oh, rbw, mw, dn, er};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] s);
    return 4'b1000 >> s;
  endfunction

  // Compare process: every cycle that has a queued expectation is checked at the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      checkOutput("ctl", {req_ready, src_alu, src_register_bank, src_decoder, src_memory,
                          rb_we, mem_we, done, err}, cur.ctl);
      checkOutput("data", {alu_a_q, alu_b_q, wdata, rb_waddr}, {cur.a, cur.b, cur.w, cur.wa});
      mem_we_cycles  += int'(mem_we);
      src_mem_cycles += int'(src_memory);
    end
  end

  task automatic stepCycle(input logic v, input logic [31:0] bus, input logic ack, input logic [8:0] ctl);
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = v;
    bus_in    = bus;
    mem_ack   = ack;
    e.ctl = ctl; e.a = m_a; e.b = m_b; e.w = m_w; e.wa = m_wa;
    exp_q.push_back(e);
  endtask

  // ack_delay: number of memory wait cycles without ack before the ack cycle; -1 means never.
  task automatic applyStimulus(input logic [1:0] src, input logic [1:0] dst, input logic [4:0] addr,
                               input logic [31:0] data, input int ack_delay);
    logic to;
    int   n;
    to = (ack_delay < 0) || (ack_delay >= TIMEOUT);
    n  = to ? TIMEOUT : ack_delay + 1;
    mem_we_cycles  = 0;
    src_mem_cycles = 0;
    req_src     = src;
    req_dst     = dst;
    req_rd_addr = addr;
    stepCycle(1'b1, $urandom, 1'($urandom_range(0, 1)), mk(1, 0, 0, 0, 0, 0));
    m_wa = addr;
    if (src == 2'd3 && dst == 2'd3) begin
      stepCycle(1'b0, $urandom, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 1, 1));
    end else begin
      if (src == 2'd3) begin
        for (int i = 0; i < n; i++)
          stepCycle(1'b0, (!to && i == n - 1) ? data : $urandom, !to && i == n - 1,
                    mk(0, onehot(src), 0, 0, 0, 0));
      end else begin
        stepCycle(1'b0, data, 1'($urandom_range(0, 1)), mk(0, onehot(src), 0, 0, 0, 0));
        to = 1'b0;
      end
      if (!to) begin
        m_w = data;
        if (dst == 2'd3) begin
          to = (ack_delay < 0) || (ack_delay >= TIMEOUT);
          for (int i = 0; i < n; i++)
            stepCycle(1'b0, $urandom, !to && i == n - 1, mk(0, 0, 0, 1, 0, 0));
        end else begin
          stepCycle(1'b0, $urandom, 1'($urandom_range(0, 1)), mk(0, 0, dst == 2'd2, 0, 0, 0));
          if (dst == 2'd0) m_a = m_w;
          if (dst == 2'd1) m_b = m_w;
        end
      end
      stepCycle(1'b0, $urandom, 1'($urandom_range(0, 1)), mk(0, 0, 0, 0, 1, to));
    end
    stepCycle(1'b0, $urandom, 1'b0, mk(1, 0, 0, 0, 0, 0));
  endtask

  initial begin
    logic done_seen;
    rst_n = 1'b0; req_valid = 1'b0; req_src = '0; req_dst = '0; req_rd_addr = '0;
    bus_in = '0; mem_ack = 1'b0;
    m_a = '0; m_b = '0; m_w = '0; m_wa = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_ctl", {req_ready, src_alu, src_register_bank, src_decoder, src_memory,
                              rb_we, mem_we, done, err}, 9'b1_0000_0000);
    checkOutput("reset_data", {alu_a_q, alu_b_q, wdata, rb_waddr}, '0);

    // Reset in the middle of a memory-sourced drive
    $display("[TB] reset mid-transfer");
    req_src = 2'd3; req_dst = 2'd0; req_rd_addr = 5'd7;
    @(posedge clk); #1 req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    checkOutput("rst_pre_src_memory", src_memory, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_outputs", {src_alu, src_register_bank, src_decoder, src_memory,
                                      rb_we, mem_we, done, err}, 0);
    checkOutput("rst_ready", req_ready, 1);
    checkOutput("rst_waddr", rb_waddr, 0);
    #1 rst_n = 1'b1;
    done_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      done_seen |= done;
    end
    checkOutput("rst_no_done", done_seen, 0);
    checkOutput("rst_idle_ready", req_ready, 1);

    $display("[TB] test 1 decoder->A");
    applyStimulus(2'd2, 2'd0, 5'd0, 32'h0000_1234, 0);
    checkOutput("t1_alu_a", alu_a_q, 32'h1234);
    checkOutput("t1_alu_b", alu_b_q, 32'h0);

    $display("[TB] test 2 alu->register_bank");
    applyStimulus(2'd0, 2'd2, 5'd5, 32'hDEAD_BEEF, 0);
    checkOutput("t2_wdata", wdata, 32'hDEAD_BEEF);
    checkOutput("t2_waddr", rb_waddr, 5);

    $display("[TB] test 3 memory->B");
    applyStimulus(2'd3, 2'd1, 5'd9, 32'hA5A5_0001, 3);
    checkOutput("t3_src_mem_cycles", src_mem_cycles, 4);
    checkOutput("t3_alu_b", alu_b_q, 32'hA5A5_0001);
    checkOutput("t3_alu_a", alu_a_q, 32'h1234);

    $display("[TB] test 4 register_bank->memory timeout");
    applyStimulus(2'd1, 2'd3, 5'd1, 32'h0BAD_F00D, -1);
    checkOutput("t4a_mem_we_cycles", mem_we_cycles, 15);

    $display("[TB] test 4 ack on the last allowed cycle");
    applyStimulus(2'd1, 2'd3, 5'd2, 32'h1111_2222, TIMEOUT - 1);
    checkOutput("t4b_mem_we_cycles", mem_we_cycles, 15);

    $display("[TB] test 5 mem->mem");
    applyStimulus(2'd3, 2'd3, 5'd3, 32'h0, 0);
    checkOutput("t5_src_mem_cycles", src_mem_cycles, 0);

    $display("[TB] extra transfers");
    applyStimulus(2'd3, 2'd2, 5'd12, 32'h5555_AAAA, -1);
    checkOutput("x1_src_mem_cycles", src_mem_cycles, 15);
    applyStimulus(2'd2, 2'd3, 5'd4, 32'h7777_0000, 0);
    applyStimulus(2'd3, 2'd0, 5'd31, 32'hCAFE_0042, 0);
    applyStimulus(2'd1, 2'd1, 5'd6, 32'h0000_BEEF, 0);
    checkOutput("x_alu_a", alu_a_q, 32'hCAFE_0042);
    checkOutput("x_alu_b", alu_b_q, 32'h0000_BEEF);

    repeat (2) @(posedge clk);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
